// File: rtl/tx_control.sv
// Transmit sequencer for the UART calculator link: latches a result word and sends it LSB byte first.
// Optional macro TX_CHECKSUM_EN appends an XOR-of-bytes checksum as a final byte.
module tx_control #(
  parameter  int N_BYTES = 2,
  localparam int DATA_W  = 8 * N_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic [DATA_W-1:0] result,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done
);

`ifdef TX_CHECKSUM_EN
  localparam int N_TX = N_BYTES + 1;
`else
  localparam int N_TX = N_BYTES;
`endif
  localparam int SH_W  = 8 * N_TX;
  localparam int CNT_W = $clog2(N_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TX - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_FREE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic [SH_W-1:0]   shreg_next;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;

`ifdef TX_CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [DATA_W-1:0] w);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < N_BYTES; i++) begin
      acc = acc ^ w[8*i +: 8];
    end
    return acc;
  endfunction
`endif

  assign shreg_next = shreg_q >> 8;

  // tx_data is loaded on entry to SEND so it is already valid while tx_start is high
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (trigger && !tx_busy) begin
`ifdef TX_CHECKSUM_EN
          shreg_d = {xor_bytes(result), result};
`else
          shreg_d = result;
`endif
          cnt_d     = '0;
          tx_data_d = result[7:0];
          state_d   = SEND;
        end
      end
      SEND: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_FREE;
        end
      end
      WAIT_FREE: begin
        if (!tx_busy) begin
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            shreg_d   = shreg_next;
            tx_data_d = shreg_next[7:0];
            cnt_d     = cnt_q + CNT_W'(1);
            state_d   = SEND;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_start = (state_q == SEND);
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_tx_control.sv
// Directed bench for tx_control with a UART transmitter model that stays busy 10 cycles per byte.
module tb_tx_control;

  logic        clk;
  logic        reset;
  logic        trigger;
  logic [15:0] result;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int passed = 0;

  logic       man_busy;
  int         busy_cnt;
  logic [7:0] got_q[$];
  int         done_cnt;
  int         overlap_cnt;

  tx_control #(.N_BYTES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .trigger  (trigger),
    .result   (result),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // transmitter model: busy for 10 cycles after each accepted tx_start
  always @(posedge clk or negedge reset) begin
    if (!reset) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || man_busy;

  always @(negedge clk) begin
    if (tx_start) got_q.push_back(tx_data);
    if (done) done_cnt++;
    if (tx_start && tx_busy) overlap_cnt++;
  end

  task automatic clear_mon();
    got_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_trigger(input logic [15:0] r);
    @(negedge clk);
    trigger = 1'b1;
    result  = r;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start got %b want 0", tx_start); else passed++;
    checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp_q[$];
    bit to;
    exp_q = '{8'h34, 8'h12};
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(8'h26);
`endif
    clear_mon();
    @(negedge clk);
    trigger = 1'b1;
    result  = 16'h1234;
    @(negedge clk);
    trigger = 1'b0;
    checks++; if (tx_start !== 1'b1) $display("FAIL basic_latency tx_start got %b want 1", tx_start); else passed++;
    checks++; if (tx_data !== 8'h34) $display("FAIL basic_first_data got %h want 34", tx_data); else passed++;
    @(negedge clk);
    checks++; if (tx_start !== 1'b0) $display("FAIL basic_start_width got %b want 0", tx_start); else passed++;
    wait_idle(to);
    checks++; if (to) $display("FAIL basic_timeout got busy want idle"); else passed++;
    @(negedge clk);
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL basic_byte%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
    end
    checks++; if (done_cnt != 1) $display("FAIL basic_done got %0d want 1", done_cnt); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy); else passed++;
  endtask

  task automatic test_busy_drop();
    logic [7:0] exp_q[$];
    bit to;
    exp_q = '{8'hCD, 8'hAB};
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(8'h66);
`endif
    clear_mon();
    man_busy = 1'b1;
    pulse_trigger(16'hABCD);
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL drop_busy got %b want 0", busy); else passed++;
    checks++; if (got_q.size() != 0) $display("FAIL drop_no_start got %0d starts want 0", got_q.size()); else passed++;
    man_busy = 1'b0;
    pulse_trigger(16'hABCD);
    wait_idle(to);
    checks++; if (to) $display("FAIL drop_timeout got busy want idle"); else passed++;
    @(negedge clk);
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL drop_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL drop_byte%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_result_change();
    logic [7:0] exp_q[$];
    bit to;
    exp_q = '{8'hFF, 8'h00};
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(8'hFF);
`endif
    clear_mon();
    pulse_trigger(16'h00FF);
    result = 16'h5555;
    trigger = 1'b1;
    repeat (3) @(negedge clk);
    trigger = 1'b0;
    wait_idle(to);
    checks++; if (to) $display("FAIL change_timeout got busy want idle"); else passed++;
    @(negedge clk);
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL change_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL change_byte%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int starts;
    clear_mon();
    pulse_trigger(16'h1234);
    repeat (4) @(negedge clk);
    checks++; if (!(busy && tx_busy)) $display("FAIL midrst_setup got busy=%b tx_busy=%b want 1 1", busy, tx_busy); else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0) $display("FAIL midrst_tx_start got %b want 0", tx_start); else passed++;
    checks++; if (tx_data !== 8'h00) $display("FAIL midrst_tx_data got %h want 00", tx_data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else passed++;
    starts = got_q.size();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (got_q.size() != starts) $display("FAIL midrst_spurious got %0d starts want %0d", got_q.size(), starts); else passed++;
    checks++; if (done_cnt != 0) $display("FAIL midrst_done_cnt got %0d want 0", done_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    bit to;
    bit seen;
`ifdef TX_CHECKSUM_EN
    exp_q = '{8'h02, 8'h01, 8'h03, 8'h04, 8'h03, 8'h07};
`else
    exp_q = '{8'h02, 8'h01, 8'h04, 8'h03};
`endif
    clear_mon();
    pulse_trigger(16'h0102);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!seen) $display("FAIL b2b_first_done got timeout want done"); else passed++;
    @(negedge clk);
    trigger = 1'b1;
    result  = 16'h0304;
    @(negedge clk);
    trigger = 1'b0;
    checks++; if (tx_start !== 1'b1) $display("FAIL b2b_accept tx_start got %b want 1", tx_start); else passed++;
    wait_idle(to);
    checks++; if (to) $display("FAIL b2b_timeout got busy want idle"); else passed++;
    @(negedge clk);
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
    end
    checks++; if (done_cnt != 2) $display("FAIL b2b_done got %0d want 2", done_cnt); else passed++;
    checks++; if (overlap_cnt != 0) $display("FAIL start_while_busy got %0d want 0", overlap_cnt); else passed++;
  endtask

  initial begin
    trigger     = 1'b0;
    result      = 16'h0000;
    man_busy    = 1'b0;
    done_cnt    = 0;
    overlap_cnt = 0;
    reset       = 1'b0;
    test_reset();
    test_basic();
    test_busy_drop();
    test_result_change();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
